// File: rtl/axi4_mem_slave_if.sv
// rtl/axi4_mem_slave_if.sv - AXI4 slave port plus native memory port bundle for axi4_mem_slave
interface axi4_mem_slave_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8
);
  logic [AXI_ID_W-1:0]     s_axi_awid;
  logic [AXI_ADDR_W-1:0]   s_axi_awaddr;
  logic [AXI_LEN_W-1:0]    s_axi_awlen;
  logic [2:0]              s_axi_awsize;
  logic [1:0]              s_axi_awburst;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [AXI_DATA_W-1:0]   s_axi_wdata;
  logic [AXI_DATA_W/8-1:0] s_axi_wstrb;
  logic                    s_axi_wlast;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [AXI_ID_W-1:0]     s_axi_bid;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [AXI_ID_W-1:0]     s_axi_arid;
  logic [AXI_ADDR_W-1:0]   s_axi_araddr;
  logic [AXI_LEN_W-1:0]    s_axi_arlen;
  logic [2:0]              s_axi_arsize;
  logic [1:0]              s_axi_arburst;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [AXI_ID_W-1:0]     s_axi_rid;
  logic [AXI_DATA_W-1:0]   s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rlast;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;
  logic                    mem_valid;
  logic [AXI_ADDR_W-1:0]   mem_addr;
  logic [AXI_DATA_W-1:0]   mem_wdata;
  logic [AXI_DATA_W/8-1:0] mem_wstrb;
  logic [AXI_DATA_W-1:0]   mem_rdata;
  logic                    mem_ready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/axi4_mem_slave.sv
// rtl/axi4_mem_slave.sv - AXI4 INCR-burst slave to single-word native memory port
// Optional burst/size/wlast checking with SLVERR responses: define AXI_SLV_ERR_CHECK_EN.
module axi4_mem_slave #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1,
  parameter int AXI_LEN_W  = 8
) (
  input logic            clk,
  input logic            rst,
  axi4_mem_slave_if.slave bus
);
`ifdef AXI_SLV_ERR_CHECK_EN
  localparam bit ERR_CHECK = 1'b1;
`else
  localparam bit ERR_CHECK = 1'b0;
`endif
  localparam logic [AXI_ADDR_W-1:0] BEAT_BYTES = AXI_ADDR_W'(AXI_DATA_W / 8);

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

  state_t                state;
  logic [AXI_ADDR_W-1:0] addr;
  logic [AXI_LEN_W-1:0]  cnt;
  logic                  prio_wr;
  logic                  rd_left;
  logic                  xfer_err;
  logic                  wlast_err;
  logic                  aw_bad, ar_bad, rd_slot, rd_adv, wr_beat, last_beat;

  always_comb begin
    aw_bad    = ERR_CHECK && (bus.s_axi_awburst != 2'b01 || bus.s_axi_awsize != 3'b010);
    ar_bad    = ERR_CHECK && (bus.s_axi_arburst != 2'b01 || bus.s_axi_arsize != 3'b010);
    last_beat = (cnt == '0);
    // A read beat may be fetched only when the R register is empty or draining this cycle.
    rd_slot   = (state == RD_DATA) && rd_left && (!bus.s_axi_rvalid || bus.s_axi_rready);
    rd_adv    = rd_slot && (xfer_err || bus.mem_ready);
    wr_beat   = (state == WR_DATA) && bus.s_axi_wvalid && bus.s_axi_wready;
  end

  assign bus.mem_valid = ((state == WR_DATA) && bus.s_axi_wvalid && (bus.s_axi_wstrb != 4'b0000)
                          && !xfer_err) || (rd_slot && !xfer_err);
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = bus.s_axi_wdata;
  assign bus.mem_wstrb = ((state == WR_DATA) && !xfer_err) ? bus.s_axi_wstrb : 4'b0000;
  assign bus.s_axi_wready = (state == WR_DATA) &&
                            (xfer_err || (bus.s_axi_wstrb == 4'b0000) || bus.mem_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      addr              <= '0;
      cnt               <= '0;
      prio_wr           <= 1'b1;
      rd_left           <= 1'b0;
      xfer_err          <= 1'b0;
      wlast_err         <= 1'b0;
      bus.s_axi_awready <= 1'b0;
      bus.s_axi_arready <= 1'b0;
      bus.s_axi_bvalid  <= 1'b0;
      bus.s_axi_bresp   <= 2'b00;
      bus.s_axi_bid     <= AXI_ID_W'(0);
      bus.s_axi_rvalid  <= 1'b0;
      bus.s_axi_rdata   <= '0;
      bus.s_axi_rresp   <= 2'b00;
      bus.s_axi_rlast   <= 1'b0;
      bus.s_axi_rid     <= AXI_ID_W'(0);
    end else begin
      case (state)
        IDLE: begin
          // Ready is a registered one-cycle pulse; the request is captured in the pulse cycle.
          if (bus.s_axi_awready) begin
            bus.s_axi_awready <= 1'b0;
            if (bus.s_axi_awvalid) begin
              bus.s_axi_bid <= bus.s_axi_awid;
              addr          <= {bus.s_axi_awaddr[AXI_ADDR_W-1:2], 2'b00};
              cnt           <= bus.s_axi_awlen;
              xfer_err      <= aw_bad;
              wlast_err     <= 1'b0;
              state         <= WR_DATA;
            end
          end else if (bus.s_axi_arready) begin
            bus.s_axi_arready <= 1'b0;
            if (bus.s_axi_arvalid) begin
              bus.s_axi_rid <= bus.s_axi_arid;
              addr          <= {bus.s_axi_araddr[AXI_ADDR_W-1:2], 2'b00};
              cnt           <= bus.s_axi_arlen;
              xfer_err      <= ar_bad;
              rd_left       <= 1'b1;
              state         <= RD_DATA;
            end
          end else if (bus.s_axi_awvalid && (prio_wr || !bus.s_axi_arvalid)) begin
            bus.s_axi_awready <= 1'b1;
            prio_wr           <= ~prio_wr;
          end else if (bus.s_axi_arvalid) begin
            bus.s_axi_arready <= 1'b1;
            prio_wr           <= ~prio_wr;
          end
        end
        WR_DATA: begin
          if (wr_beat) begin
            addr <= addr + BEAT_BYTES;
            cnt  <= cnt - AXI_LEN_W'(1);
            if (ERR_CHECK && (bus.s_axi_wlast != last_beat))
              wlast_err <= 1'b1;
            if (last_beat) begin
              state            <= WR_RESP;
              bus.s_axi_bvalid <= 1'b1;
              bus.s_axi_bresp  <= (xfer_err || wlast_err || (ERR_CHECK && !bus.s_axi_wlast))
                                  ? 2'b10 : 2'b00;
            end
          end
        end
        WR_RESP: begin
          if (bus.s_axi_bready) begin
            bus.s_axi_bvalid <= 1'b0;
            state            <= IDLE;
          end
        end
        RD_DATA: begin
          if (rd_adv) begin
            bus.s_axi_rdata  <= xfer_err ? '0 : bus.mem_rdata;
            bus.s_axi_rresp  <= xfer_err ? 2'b10 : 2'b00;
            bus.s_axi_rvalid <= 1'b1;
            bus.s_axi_rlast  <= last_beat;
            addr             <= addr + BEAT_BYTES;
            cnt              <= cnt - AXI_LEN_W'(1);
            if (last_beat)
              rd_left <= 1'b0;
          end else if (bus.s_axi_rvalid && bus.s_axi_rready) begin
            bus.s_axi_rvalid <= 1'b0;
            bus.s_axi_rlast  <= 1'b0;
            if (bus.s_axi_rlast)
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/axi4_mem_slave.md
Name: axi4_mem_slave

Overview:
- AXI4 slave (responder) that serves INCR bursts issued by DMA masters and turns each beat into a single-word access on a native memory port (valid/ready, 32-bit, byte strobes).
- Sits between the AXI interconnect and on-chip RAM or the SDRAM controller native port. It is the target side of the DMA engine's burst traffic.
- One outstanding transaction at a time; reads and writes are arbitrated round-robin.

Parameters:
- AXI_ADDR_W, 32, AXI and memory address width.
- AXI_DATA_W, 32, data width; fixed at 32 (strobe logic is 4 bits).
- AXI_ID_W, 1, width of AWID/ARID/BID/RID.
- AXI_LEN_W, 8, burst length field width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_axi_awid  in  AXI_ID_W  write address ID
- s_axi_awaddr  in  AXI_ADDR_W  write burst start address
- s_axi_awlen  in  AXI_LEN_W  beats-1
- s_axi_awsize  in  3  beat size (2 expected)
- s_axi_awburst  in  2  burst type (01 INCR expected)
- s_axi_awvalid  in  1  AW valid
- s_axi_awready  out  1  AW ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  write byte strobes
- s_axi_wlast  in  1  last write beat
- s_axi_wvalid  in  1  W valid
- s_axi_wready  out  1  W ready
- s_axi_bid  out  AXI_ID_W  response ID
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  B valid
- s_axi_bready  in  1  B ready
- s_axi_arid  in  AXI_ID_W  read address ID
- s_axi_araddr  in  AXI_ADDR_W  read burst start address
- s_axi_arlen  in  AXI_LEN_W  beats-1
- s_axi_arsize  in  3  beat size
- s_axi_arburst  in  2  burst type
- s_axi_arvalid  in  1  AR valid
- s_axi_arready  out  1  AR ready
- s_axi_rid  out  AXI_ID_W  read ID
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rlast  out  1  last read beat
- s_axi_rvalid  out  1  R valid
- s_axi_rready  in  1  R ready
- mem_valid  out  1  memory request
- mem_addr  out  AXI_ADDR_W  word-aligned byte address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte enables; 0 means read
- mem_rdata  in  32  read data, valid in the mem_ready cycle
- mem_ready  in  1  request accepted/completed this cycle

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock. On reset:
  - all ready and valid outputs are 0; bresp, rresp, rdata, rid and bid are 0.
  - state is IDLE and the round-robin priority favours write.
- IDLE state:
  - Only one of awready/arready pulses high for one cycle, accepting exactly one request.
  - Accepted channel latches id, addr with [1:0] forced to 00, and len into a beat counter. Then go to WR_DATA or RD_DATA.
  - If both awvalid and arvalid are high, the channel not served last wins. The priority flag toggles on every grant.
- WR_DATA state:
  - mem_valid = s_axi_wvalid; mem_addr = burst address; mem_wdata/mem_wstrb come from the W channel.
  - s_axi_wready = mem_ready, combinational. A beat completes when wvalid & wready.
  - On each completed beat: address += 4 and the counter decrements.
  - Beat with counter==0 → WR_RESP.
  - wstrb=0 on a write beat: issue no mem access, complete the beat with wready=1.
- WR_RESP state:
  - bvalid=1, bresp=OKAY (00), bid = latched id; hold until bready, then → IDLE.
- RD_DATA state:
  - mem_valid = (beats remaining) & (!rvalid | rready); mem_wstrb=0.
  - On mem_ready: register mem_rdata into rdata, rvalid=1, rlast=(counter==0). Address += 4, counter decrements.
  - rvalid, rdata and rlast hold stable while rready=0.
  - After the rlast beat handshakes → IDLE. Back-to-back beats are sustained when mem_ready and rready are both high.
- Address arithmetic:
  - Increment is modulo 2^AXI_ADDR_W, with no 4 KB boundary check; the master guarantees it.
  - awsize/arsize are treated as 2 regardless of their value.
- wlast is ignored for sequencing; the beat counter is authoritative.
- Single outstanding transaction: no AW/AR is accepted outside IDLE.
- Reset asserted mid-burst aborts immediately: the memory transaction in flight is dropped and outputs return to reset values.

Optional Feature:
- AXI_SLV_ERR_CHECK_EN
- When defined:
  - burst≠INCR or size≠2 on AW/AR marks the transaction in error. Write error: beats are consumed (wready=1) with no mem_valid, and bresp=SLVERR (10). Read error: beats return rdata=0, rresp=SLVERR, with no mem access.
  - wlast mismatching counter==0 sets bresp=SLVERR, while the mem writes still occur.
- When not defined: no checks; bresp and rresp are always 00.

Test Plan:
- Write burst awaddr=0x100, awlen=3, data 0xA0..0xA3, wstrb=F, mem_ready always 1 → mem writes at 0x100,0x104,0x108,0x10C with wstrb F; one bvalid, bresp=00, bid=awid.
- Read burst araddr=0x200, arlen=255, mem returns addr-based data → 256 R beats, rlast only on beat 256, addresses 0x200..0x5FC.
- Read with rready toggling 1-0-1 and mem_ready random → no beat lost or duplicated, and rdata stable while rvalid & !rready.
- AW and AR asserted together in the same cycle, twice → write granted first, read second; a third simultaneous pair grants write again.
- rst pulsed in the middle of a write burst of awlen=7 after 3 beats → all outputs 0 next cycle; a new write burst then completes normally.
- With AXI_SLV_ERR_CHECK_EN, arburst=00 and arlen=1 → 2 beats with rresp=10, rdata=0 and mem_valid never high.
